// File: rtl/q_sys_descriptor_fetcher_pkg.sv
// Shared types for the descriptor fetcher: FSM states, descriptor word layout and
// the write-back word format.
package q_sys_descriptor_fetcher_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_RD_REQ,
        ST_RD_DATA,
        ST_CHECK,
        ST_EMIT,
        ST_EXEC,
        ST_WB,
        ST_NEXT
    } state_e;

    localparam logic [1:0] WORD_SRC  = 2'd0;
    localparam logic [1:0] WORD_DST  = 2'd1;
    localparam logic [1:0] WORD_NEXT = 2'd2;
    localparam logic [1:0] WORD_CTRL = 2'd3;

    localparam int OWNED_BY_HW_BIT = 31;

    typedef struct packed {
        logic [31:0] src;
        logic [31:0] dst;
        logic [31:0] next;
        logic [31:0] ctrl;
    } desc_t;

    function automatic desc_t set_word(desc_t d, logic [1:0] idx, logic [31:0] w);
        desc_t r;
        r = d;
        case (idx)
            WORD_SRC:  r.src  = w;
            WORD_DST:  r.dst  = w;
            WORD_NEXT: r.next = w;
            default:   r.ctrl = w;
        endcase
        return r;
    endfunction

    // Ownership returns to software; the consumer's status replaces the old status byte.
    function automatic logic [31:0] writeback_word(logic [31:0] ctrl, logic [7:0] status);
        return {1'b0, ctrl[OWNED_BY_HW_BIT-1:24], status, ctrl[15:0]};
    endfunction

endpackage

// File: rtl/q_sys_descriptor_fetcher_if.sv
// Avalon-MM master bus plus the descriptor/transfer handshake of the fetcher.
interface q_sys_descriptor_fetcher_if #(
    parameter int ADDR_W = 11
);
    logic [ADDR_W-1:0] m_address;
    logic              m_read;
    logic              m_write;
    logic [3:0]        m_byteenable;
    logic [31:0]       m_writedata;
    logic [31:0]       m_readdata;
    logic              m_waitrequest;

    logic              desc_valid;
    logic              desc_ready;
    logic [31:0]       desc_src;
    logic [31:0]       desc_dst;
    logic [15:0]       desc_len;
    logic              xfer_done;
    logic [7:0]        xfer_status;

    modport master (
        output m_address, m_read, m_write, m_byteenable, m_writedata,
        input  m_readdata, m_waitrequest,
        output desc_valid, desc_src, desc_dst, desc_len,
        input  desc_ready, xfer_done, xfer_status
    );

    modport slave (
        input  m_address, m_read, m_write, m_byteenable, m_writedata,
        output m_readdata, m_waitrequest,
        input  desc_valid, desc_src, desc_dst, desc_len,
        output desc_ready, xfer_done, xfer_status
    );
endinterface

// File: rtl/q_sys_descriptor_fetcher.sv
// Walks a linked list of 4-word descriptors: fetch, hand to the consumer, write back
// status with ownership cleared, then follow the next pointer.
module q_sys_descriptor_fetcher
    import q_sys_descriptor_fetcher_pkg::*;
#(
    parameter int ADDR_W    = 11,
    parameter int MAX_CHAIN = 255
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       start,
    input  logic [ADDR_W-1:0]          head_addr,
    q_sys_descriptor_fetcher_if.master bus,
    output logic                       busy,
    output logic                       chain_done,
    output logic                       chain_error
);
    localparam int CNT_W = $clog2(MAX_CHAIN + 1);

    state_e            state_q, state_d;
    logic [ADDR_W-1:0] base_q, base_d;
    logic [1:0]        idx_q, idx_d;
    logic [CNT_W-1:0]  count_q, count_d;
    desc_t             desc_q, desc_d;
    logic [7:0]        status_q, status_d;
    logic [ADDR_W-1:0] next_ptr;

    assign next_ptr         = desc_q.next[ADDR_W-1:0];
    assign busy             = (state_q != ST_IDLE);
    assign bus.m_byteenable = 4'b1111;
    assign bus.desc_src     = desc_q.src;
    assign bus.desc_dst     = desc_q.dst;
    assign bus.desc_len     = desc_q.ctrl[15:0];

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q  <= ST_IDLE;
            base_q   <= '0;
            idx_q    <= '0;
            count_q  <= '0;
            // NOTE: the descriptor holding registers are reset because desc_* are driven straight from them.
            desc_q   <= '0;
            status_q <= '0;
        end else begin
            state_q  <= state_d;
            base_q   <= base_d;
            idx_q    <= idx_d;
            count_q  <= count_d;
            desc_q   <= desc_d;
            status_q <= status_d;
        end
    end

    always_comb begin
        // NOTE: every next-state value and output gets a default first so no path infers a latch.
        state_d         = state_q;
        base_d          = base_q;
        idx_d           = idx_q;
        count_d         = count_q;
        desc_d          = desc_q;
        status_d        = status_q;
        bus.m_read      = 1'b0;
        bus.m_write     = 1'b0;
        bus.m_address   = '0;
        bus.m_writedata = '0;
        bus.desc_valid  = 1'b0;
        chain_done      = 1'b0;
        chain_error     = 1'b0;

        unique case (state_q)
            ST_IDLE: begin
                if (start) begin
                    base_d  = head_addr;
                    idx_d   = '0;
                    count_d = '0;
                    state_d = ST_RD_REQ;
                end
            end
            ST_RD_REQ: begin
                bus.m_read    = 1'b1;
                bus.m_address = base_q + ADDR_W'(idx_q);
                if (!bus.m_waitrequest) state_d = ST_RD_DATA;
            end
            ST_RD_DATA: begin
                desc_d = set_word(desc_q, idx_q, bus.m_readdata);
                if (idx_q == WORD_CTRL) begin
                    state_d = ST_CHECK;
                end else begin
                    idx_d   = idx_q + 2'd1;
                    state_d = ST_RD_REQ;
                end
            end
            ST_CHECK: begin
                if (desc_q.ctrl[OWNED_BY_HW_BIT]) begin
                    state_d = ST_EMIT;
                end else begin
                    chain_done = 1'b1;
                    state_d    = ST_IDLE;
                end
            end
            ST_EMIT: begin
                bus.desc_valid = 1'b1;
                if (bus.desc_ready) state_d = ST_EXEC;
            end
            ST_EXEC: begin
                if (bus.xfer_done) begin
                    status_d = bus.xfer_status;
                    state_d  = ST_WB;
                end
            end
            ST_WB: begin
                bus.m_write     = 1'b1;
                bus.m_address   = base_q + ADDR_W'(WORD_CTRL);
                bus.m_writedata = writeback_word(desc_q.ctrl, status_q);
                if (!bus.m_waitrequest) state_d = ST_NEXT;
            end
            ST_NEXT: begin
                count_d = count_q + CNT_W'(1);
                // Abort on chain-length overflow or a descriptor that points at itself.
                if (count_q == CNT_W'(MAX_CHAIN - 1) || next_ptr == base_q) begin
                    chain_error = 1'b1;
                    state_d     = ST_IDLE;
                end else begin
                    base_d  = next_ptr;
                    idx_d   = '0;
                    state_d = ST_RD_REQ;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

endmodule

// File: tb/tb_q_sys_descriptor_fetcher.sv
// Scoreboard bench: a chain-walk model fills expectation queues; memory-slave,
// consumer and outcome monitors pop and compare as the DUT presents traffic.
module tb_q_sys_descriptor_fetcher;
    localparam int ADDR_W    = 11;
    localparam int MAX_CHAIN = 255;
    localparam int MEM_WORDS = 1 << ADDR_W;

    logic              clk = 1'b0;
    logic              reset;
    logic              start;
    logic [ADDR_W-1:0] head_addr;
    logic              busy;
    logic              chain_done;
    logic              chain_error;

    q_sys_descriptor_fetcher_if #(.ADDR_W(ADDR_W)) bus ();

    q_sys_descriptor_fetcher #(.ADDR_W(ADDR_W), .MAX_CHAIN(MAX_CHAIN)) dut (
        .clk        (clk),
        .reset      (reset),
        .start      (start),
        .head_addr  (head_addr),
        .bus        (bus),
        .busy       (busy),
        .chain_done (chain_done),
        .chain_error(chain_error)
    );

    always #5 clk = ~clk;

    typedef struct { logic [31:0] src; logic [31:0] dst; logic [15:0] len; } emit_t;
    typedef struct { logic [ADDR_W-1:0] addr; logic [31:0] data; } wr_t;

    logic [31:0]       mem       [MEM_WORDS];
    logic [31:0]       model_mem [MEM_WORDS];
    logic [ADDR_W-1:0] exp_reads[$];
    emit_t             exp_emits[$];
    wr_t               exp_writes[$];
    int                exp_outcome[$];   // 0 = chain_done, 1 = chain_error
    logic [7:0]        status_plan[$];

    int n_checks    = 0;
    int n_fail      = 0;
    int wait_en     = 0;
    int ready_delay = -1;
    int done_noise  = 0;
    int hold_write  = 0;

    task automatic check(input string name, input logic [31:0] actual, input logic [31:0] expected);
        n_checks++;
        if (actual !== expected) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, actual, expected);
        end
    endtask

    task automatic fail_now(input string name, input logic [31:0] actual);
        n_checks++;
        n_fail++;
        $display("FAIL %s: got 0x%08h while nothing was expected", name, actual);
    endtask

    // Chain walk from the rules: read 4 words, stop if not owned, emit, write back,
    // then stop on length limit or self-pointer, else follow the pointer.
    task automatic run_model(input logic [ADDR_W-1:0] head, input int fixed_status);
        logic [ADDR_W-1:0] b;
        logic [ADDR_W-1:0] a;
        logic [31:0]       w [4];
        logic [7:0]        st;
        logic [31:0]       wb;
        int                cnt;
        for (int i = 0; i < MEM_WORDS; i++) model_mem[i] = mem[i];
        b   = head;
        cnt = 0;
        while (1) begin
            for (int i = 0; i < 4; i++) begin
                a = b + ADDR_W'(i);
                exp_reads.push_back(a);
                w[i] = model_mem[a];
            end
            if (w[3][31] == 1'b0) begin
                exp_outcome.push_back(0);
                break;
            end
            exp_emits.push_back('{src: w[0], dst: w[1], len: w[3][15:0]});
            st = (fixed_status >= 0) ? 8'(fixed_status) : 8'($urandom_range(0, 255));
            status_plan.push_back(st);
            wb = (w[3] & 32'h7F00_FFFF) | {8'h00, st, 16'h0000};
            a  = b + ADDR_W'(3);
            exp_writes.push_back('{addr: a, data: wb});
            model_mem[a] = wb;
            cnt++;
            if (cnt == MAX_CHAIN || w[2][ADDR_W-1:0] == b) begin
                exp_outcome.push_back(1);
                break;
            end
            b = w[2][ADDR_W-1:0];
        end
    endtask

    task automatic clear_mem();
        for (int i = 0; i < MEM_WORDS; i++) mem[i] = 32'h0;
    endtask

    task automatic load_desc(input logic [ADDR_W-1:0] base, input logic [31:0] w0, input logic [31:0] w1,
                             input logic [31:0] w2, input logic [31:0] w3);
        mem[base]              = w0;
        mem[base + ADDR_W'(1)] = w1;
        mem[base + ADDR_W'(2)] = w2;
        mem[base + ADDR_W'(3)] = w3;
    endtask

    task automatic clear_queues();
        exp_reads.delete();
        exp_emits.delete();
        exp_writes.delete();
        exp_outcome.delete();
        status_plan.delete();
    endtask

    task automatic check_outputs_zero(input string tag);
        check({tag, "_m_read"},      32'(bus.m_read), 0);
        check({tag, "_m_write"},     32'(bus.m_write), 0);
        check({tag, "_m_address"},   32'(bus.m_address), 0);
        check({tag, "_m_writedata"}, bus.m_writedata, 0);
        check({tag, "_desc_valid"},  32'(bus.desc_valid), 0);
        check({tag, "_desc_src"},    bus.desc_src, 0);
        check({tag, "_desc_dst"},    bus.desc_dst, 0);
        check({tag, "_desc_len"},    32'(bus.desc_len), 0);
        check({tag, "_busy"},        32'(busy), 0);
        check({tag, "_chain_done"},  32'(chain_done), 0);
        check({tag, "_chain_error"}, 32'(chain_error), 0);
    endtask

    task automatic kick(input logic [ADDR_W-1:0] head, input int fixed_status, input bit measure);
        int lat;
        run_model(head, fixed_status);
        @(negedge clk);
        check("busy_before_start", 32'(busy), 0);
        head_addr = head;
        start     = 1'b1;
        @(posedge clk);
        #1;
        start     = 1'b0;
        head_addr = ADDR_W'($urandom);
        check("busy_after_start", 32'(busy), 1);
        if (measure) begin
            lat = 0;
            while (!bus.desc_valid && lat < 50) begin
                @(posedge clk);
                #1;
                lat++;
            end
            check("start_to_desc_valid_cycles", lat, 9);
        end
    endtask

    task automatic wait_done(input int budget, input bit collide);
        int  n;
        bit  seen;
        n    = 0;
        seen = 0;
        while (!seen && n < budget) begin
            @(negedge clk);
            n++;
            seen = chain_done || chain_error;
        end
        check("chain_finished_in_budget", 32'(seen), 1);
        if (collide) begin
            head_addr = ADDR_W'($urandom);
            start     = 1'b1;
            @(negedge clk);
            start = 1'b0;
        end
        repeat (3) @(negedge clk);
        if (collide) check("start_at_completion_dropped", 32'(busy), 0);
        check("reads_left",    exp_reads.size(), 0);
        check("emits_left",    exp_emits.size(), 0);
        check("writes_left",   exp_writes.size(), 0);
        check("outcomes_left", exp_outcome.size(), 0);
    endtask

    // Avalon-MM memory slave: random stalls, stability checks, expected read/write order.
    initial begin : slave
        bit                s_active;
        int                s_stall;
        logic              s_rd;
        logic              s_wr;
        logic [ADDR_W-1:0] s_addr;
        logic [31:0]       s_wdata;
        bit                rd_pending;
        logic [ADDR_W-1:0] rd_addr;
        wr_t               ew;
        s_active = 0; s_stall = 0; rd_pending = 0; rd_addr = '0;
        s_rd = 0; s_wr = 0; s_addr = '0; s_wdata = '0;
        bus.m_waitrequest = 1'b0;
        bus.m_readdata    = '0;
        forever begin
            @(negedge clk);
            if (reset) begin
                s_active = 0;
                rd_pending = 0;
                bus.m_waitrequest = 1'b0;
                bus.m_readdata    = '0;
            end else begin
                bus.m_readdata = rd_pending ? mem[rd_addr] : $urandom;
                rd_pending     = 0;
                if (bus.m_read && bus.m_write) check("read_write_exclusive", 32'(bus.m_write), 0);
                if (bus.m_read || bus.m_write) begin
                    if (!s_active) begin
                        s_active = 1;
                        s_rd = bus.m_read; s_wr = bus.m_write;
                        s_addr = bus.m_address; s_wdata = bus.m_writedata;
                        if (bus.m_write && hold_write != 0) s_stall = 1000000;
                        else if (wait_en != 0)              s_stall = $urandom_range(0, 3);
                        else                                s_stall = 0;
                    end else begin
                        check("stall_addr_stable",    32'(bus.m_address), 32'(s_addr));
                        check("stall_strobes_stable", {30'd0, bus.m_read, bus.m_write}, {30'd0, s_rd, s_wr});
                        check("stall_wdata_stable",   bus.m_writedata, s_wdata);
                    end
                    if (s_stall > 0) begin
                        bus.m_waitrequest = 1'b1;
                        s_stall--;
                    end else begin
                        bus.m_waitrequest = 1'b0;
                        s_active = 0;
                        if (bus.m_read) begin
                            if (exp_reads.size() == 0) fail_now("read_unexpected", 32'(bus.m_address));
                            else check("read_addr", 32'(bus.m_address), 32'(exp_reads.pop_front()));
                            rd_pending = 1;
                            rd_addr    = bus.m_address;
                        end else begin
                            if (exp_writes.size() == 0) begin
                                fail_now("write_unexpected", 32'(bus.m_address));
                            end else begin
                                ew = exp_writes.pop_front();
                                check("wb_addr", 32'(bus.m_address), 32'(ew.addr));
                                check("wb_data", bus.m_writedata, ew.data);
                            end
                            check("wb_byteenable", 32'(bus.m_byteenable), 32'hF);
                            mem[bus.m_address] = bus.m_writedata;
                        end
                    end
                end else begin
                    s_active = 0;
                    bus.m_waitrequest = (wait_en != 0) ? 1'($urandom_range(0, 1)) : 1'b0;
                end
            end
        end
    end

    // Descriptor consumer: checks each emit, holds ready low, then reports xfer_done.
    initial begin : consumer
        bit    c_seen;
        bit    c_exec;
        int    c_delay;
        int    c_exec_delay;
        emit_t held;
        emit_t e;
        c_seen = 0; c_exec = 0; c_delay = 0; c_exec_delay = 0;
        held = '{src: '0, dst: '0, len: '0};
        bus.desc_ready  = 1'b0;
        bus.xfer_done   = 1'b0;
        bus.xfer_status = '0;
        forever begin
            @(negedge clk);
            bus.desc_ready  = 1'b0;
            bus.xfer_done   = 1'b0;
            bus.xfer_status = 8'($urandom);
            if (reset) begin
                c_seen = 0;
                c_exec = 0;
            end else if (bus.desc_valid) begin
                if (!c_seen) begin
                    c_seen  = 1;
                    held    = '{src: bus.desc_src, dst: bus.desc_dst, len: bus.desc_len};
                    c_delay = (ready_delay >= 0) ? ready_delay : $urandom_range(0, 3);
                    if (exp_emits.size() == 0) begin
                        fail_now("emit_unexpected", bus.desc_src);
                    end else begin
                        e = exp_emits.pop_front();
                        check("desc_src", bus.desc_src, e.src);
                        check("desc_dst", bus.desc_dst, e.dst);
                        check("desc_len", 32'(bus.desc_len), 32'(e.len));
                    end
                end else begin
                    check("desc_src_stable", bus.desc_src, held.src);
                    check("desc_dst_stable", bus.desc_dst, held.dst);
                    check("desc_len_stable", 32'(bus.desc_len), 32'(held.len));
                end
                if (c_delay == 0) begin
                    bus.desc_ready = 1'b1;
                    c_seen       = 0;
                    c_exec       = 1;
                    c_exec_delay = $urandom_range(0, 4);
                end else begin
                    c_delay--;
                    if (done_noise != 0) bus.xfer_done = 1'($urandom_range(0, 1));
                end
            end else if (c_exec) begin
                if (c_exec_delay == 0) begin
                    c_exec        = 0;
                    bus.xfer_done = 1'b1;
                    if (status_plan.size() == 0) fail_now("status_unplanned", 0);
                    else bus.xfer_status = status_plan.pop_front();
                end else begin
                    c_exec_delay--;
                end
            end
        end
    end

    initial begin : outcome_monitor
        int o;
        forever begin
            @(negedge clk);
            if (!reset && (chain_done || chain_error)) begin
                if (exp_outcome.size() == 0) begin
                    fail_now("outcome_unexpected", {30'd0, chain_error, chain_done});
                end else begin
                    o = exp_outcome.pop_front();
                    check("chain_outcome", {30'd0, chain_error, chain_done}, (o == 0) ? 32'd1 : 32'd2);
                end
            end
        end
    end

    initial begin : watchdog
        #3_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog expired");
    end

    initial begin : main
        int n;
        reset = 1'b1; start = 1'b0; head_addr = '0;
        clear_mem();
        repeat (3) @(negedge clk);
        check_outputs_zero("in_reset");
        reset = 1'b0;
        @(negedge clk);
        check_outputs_zero("after_reset");

        // Single descriptor, no stalls, fixed status 0x5A, latency measured.
        load_desc(11'h010, 32'h1111_0000, 32'h2222_0000, 32'h0000_0020, 32'h8000_0040);
        kick(11'h010, 8'h5A, 1'b1);
        wait_done(500, 1'b0);
        check("single_wb_word", mem[11'h013], 32'h005A_0040);

        // Three-descriptor chain with random stalls.
        clear_mem();
        wait_en = 1;
        load_desc(11'h000, 32'hA000_0000, 32'hB000_0000, 32'h0000_0020, 32'h8312_0100);
        load_desc(11'h020, 32'hA000_0001, 32'hB000_0001, 32'h0000_0040, 32'hC4FF_0200);
        load_desc(11'h040, 32'hA000_0002, 32'hB000_0002, 32'h0000_0060, 32'hFFFF_FFFF);
        load_desc(11'h060, 32'h0, 32'h0, 32'h0, 32'h7FFF_FFFF);
        kick(11'h000, -1, 1'b0);
        wait_done(1000, 1'b0);

        // Single descriptor again, random stalls on every command.
        clear_mem();
        load_desc(11'h010, 32'h1111_0000, 32'h2222_0000, 32'h0000_0020, 32'h8000_0040);
        kick(11'h010, 8'h5A, 1'b0);
        wait_done(1000, 1'b0);
        check("stalled_wb_word", mem[11'h013], 32'h005A_0040);

        // Slow consumer: ready low 5 cycles, spurious xfer_done while emitting.
        clear_mem();
        wait_en = 0; ready_delay = 5; done_noise = 1;
        load_desc(11'h010, 32'h3333_0000, 32'h4444_0000, 32'h0000_0020, 32'h8000_0040);
        kick(11'h010, -1, 1'b0);
        wait_done(1000, 1'b0);
        ready_delay = -1;

        // Self-loop: one write-back, then error, no further reads.
        clear_mem();
        load_desc(11'h100, 32'h5555_0000, 32'h6666_0000, 32'h0000_0100, 32'h8100_0008);
        kick(11'h100, -1, 1'b0);
        wait_done(1000, 1'b0);

        // Address wrap at the top of memory; start pulsed on the completion cycle.
        clear_mem();
        wait_en = 1;
        load_desc(11'h7FE, 32'h7777_0000, 32'h8888_0000, 32'h0000_0300, 32'h8000_0010);
        kick(11'h7FE, -1, 1'b0);
        wait_done(1000, 1'b1);

        // Reset during a stalled write-back drops it; a following run completes.
        clear_mem();
        wait_en = 0; hold_write = 1;
        load_desc(11'h200, 32'h9999_0000, 32'hAAAA_0000, 32'h0000_0300, 32'h80AB_1234);
        kick(11'h200, -1, 1'b0);
        n = 0;
        while (!bus.m_write && n < 200) begin
            @(negedge clk);
            n++;
        end
        check("wb_reached_before_reset", 32'(bus.m_write), 1);
        repeat (2) @(negedge clk);
        reset = 1'b1;
        #1;
        check_outputs_zero("reset_in_wb");
        @(posedge clk);
        #1;
        check_outputs_zero("reset_next_edge");
        clear_queues();
        hold_write = 0;
        @(negedge clk);
        reset = 1'b0;
        check("wb_dropped_by_reset", mem[11'h203], 32'h80AB_1234);
        kick(11'h200, -1, 1'b0);
        wait_done(1000, 1'b0);

        // Random memory images and heads.
        done_noise = 1;
        for (int t = 0; t < 6; t++) begin
            for (int i = 0; i < MEM_WORDS; i++) mem[i] = $urandom;
            wait_en = $urandom_range(0, 1);
            kick(ADDR_W'($urandom), -1, 1'b0);
            wait_done(20000, 1'b0);
        end

        // Chain longer than MAX_CHAIN; a start while busy is ignored.
        clear_mem();
        wait_en = 0; done_noise = 0;
        for (int i = 0; i < 256; i++)
            load_desc(ADDR_W'(4 * i), $urandom, $urandom, 32'(4 * (i + 1)), {1'b1, 31'($urandom)});
        kick(11'h000, -1, 1'b0);
        repeat (40) @(negedge clk);
        head_addr = 11'h7F0;
        start     = 1'b1;
        @(negedge clk);
        start = 1'b0;
        wait_done(20000, 1'b0);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/q_sys_descriptor_fetcher.md
Q_SYS_DESCRIPTOR_FETCHER -- requirements
Module: q_sys_descriptor_fetcher

Interface
REQ-001 Parameter ADDR_W, default 11: word-address width of the descriptor memory port (2048 x 32 words).
REQ-002 Parameter MAX_CHAIN, default 255: maximum number of descriptors processed per chain before abort.
REQ-003 clk  in  1  single clock for the whole block.
REQ-004 reset  in  1  asynchronous, active-high reset.
REQ-005 start  in  1  one-cycle pulse; begins a chain walk at head_addr (ignored unless idle).
REQ-006 head_addr  in  ADDR_W  word address of the first descriptor.
REQ-007 m_address  out  ADDR_W  Avalon-MM master word address.
REQ-008 m_read / m_write  out  1 each  Avalon-MM read and write strobes.
REQ-009 m_byteenable  out  4  always 4'b1111.
REQ-010 m_writedata  out  32  write-back data.
REQ-011 m_readdata  in  32  read data, valid exactly one cycle after an accepted read.
REQ-012 m_waitrequest  in  1  slave stall; command holds while high.
REQ-013 desc_valid / desc_ready  out/in  1 each  descriptor output handshake.
REQ-014 desc_src, desc_dst  out  32 each; desc_len  out  16.
REQ-015 xfer_done  in  1  pulse: consumer finished the emitted descriptor; xfer_status  in  8.
REQ-016 busy  out  1; chain_done  out  1 (pulse); chain_error  out  1 (pulse).

Function
REQ-017 Descriptor = 4 consecutive words at base B: W0 src, W1 dst, W2 next pointer (low ADDR_W bits used), W3 {ctrl[31:24], status[23:16], len[15:0]}; ctrl[7] (bit 31) = OWNED_BY_HW.
REQ-018 States: IDLE, RD_REQ, RD_DATA, CHECK, EMIT, EXEC, WB, NEXT.
REQ-019 IDLE: start -> RD_REQ with word index 0, base = head_addr, chain count 0; busy rises next cycle.
REQ-020 RD_REQ: m_read=1, m_address=B+index (mod 2^ADDR_W wrap); held stable while m_waitrequest=1; accepted -> RD_DATA.
REQ-021 RD_DATA: capture m_readdata into word[index]; index<3 -> RD_REQ index+1; index=3 -> CHECK. Exactly one read outstanding.
REQ-022 CHECK: OWNED_BY_HW=0 -> chain_done pulse, IDLE; else EMIT.
REQ-023 EMIT: desc_valid=1 with W0, W1, W3[15:0]; data stable until desc_ready sampled high; then EXEC.
REQ-024 EXEC: wait for xfer_done; latch xfer_status -> WB. xfer_done outside EXEC ignored.
REQ-025 WB: m_write=1, m_address=B+3, m_writedata={ctrl with bit31 cleared, xfer_status, len}; held while m_waitrequest; accepted -> NEXT.
REQ-026 NEXT: count+1; count reaches MAX_CHAIN -> chain_error pulse, IDLE; next pointer equal to B -> chain_error pulse, IDLE (self-loop); else B=W2, index 0, RD_REQ.
REQ-027 m_read and m_write never asserted together; both 0 outside RD_REQ/WB.
REQ-028 start while busy ignored; start and completion in the same cycle -> completion wins, start dropped.
REQ-029 Minimum latency start->desc_valid with no wait states: 9 cycles (4 x RD_REQ/RD_DATA + CHECK).

Reset
REQ-030 Reset forces IDLE; all outputs 0: m_read, m_write, m_address, m_writedata, desc_valid, desc_src/dst/len, busy, chain_done, chain_error.
REQ-031 Reset mid-operation abandons the chain with no write-back; an in-flight write command is dropped.

Structure
REQ-032 Shared package holds state enumeration, word offsets (0..3), OWNED_BY_HW bit index, descriptor record type.
REQ-033 Single module, no sub-modules.

Verification
REQ-034 Single descriptor at 0x010 (W3=0x8000_0040), no waitrequest -> desc_valid cycle 9, len=0x0040; xfer_status=0x5A -> write 0x005A_0040 to 0x013; next W3 owned=0 -> chain_done.
REQ-035 Three-descriptor chain 0x000->0x020->0x040 -> three emits in order, three write-backs, then chain_done.
REQ-036 Random m_waitrequest 0-3 cycles on every command -> address/strobes stable while stalled, same results as REQ-034.
REQ-037 desc_ready low 5 cycles -> desc_* held stable; xfer_done pulsed during EMIT ignored.
REQ-038 W2 pointing to own base -> one write-back, then chain_error, no further reads; head at 0x7FE -> addresses wrap 0x7FE,0x7FF,0x000,0x001.
REQ-039 Reset asserted during WB stall -> outputs 0 next edge; subsequent start runs cleanly.
